// File: rtl/sync_fifo_stream.sv
// sync_fifo_stream
// Synchronous FIFO for the activation stream feeding the non-linear
// approximation engine. Binary wrap-around pointers plus an occupancy
// counter; storage is a simple-dual-port RAM with a registered read port.
//
// Optional feature: define FIFO_MARKER_FILTER_EN to compile in the in-band
// start-marker filter. Marker words are then dropped and announced on
// start_o. Without the macro every word is stored and start_o is 0.
//
// Handshake: a write is taken on any edge where wr_en is high, the FIFO
// is not full and the word is not a filtered marker; a read is taken on
// any edge where rd_en is high and the FIFO is not empty. Refused requests
// are not retried; they set the sticky overflow_o/underflow_o flags.
// A taken read shows up on data_o with valid_o high one edge later.

module sync_fifo_stream #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_LINES = 12,
   parameter int                    AF_THRESH  = (1 << ADDR_LINES) - 4,
   parameter int                    AE_THRESH  = 4,
   parameter logic [DATA_WIDTH-1:0] MARKER     = DATA_WIDTH'(32'h7F90_0000)
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  valid_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic                  almost_full_o,
   output logic                  almost_empty_o,
   output logic [ADDR_LINES:0]   count_o,
   output logic                  overflow_o,
   output logic                  underflow_o,
   output logic                  start_o
);

   localparam int DEPTH = 1 << ADDR_LINES;
   localparam int CW    = ADDR_LINES + 1;

   // Thresholds pre-sized to the counter width so the flag compares are exact
   localparam logic [CW-1:0]         DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0]         AF_C    = CW'(AF_THRESH);
   localparam logic [CW-1:0]         AE_C    = CW'(AE_THRESH);
   localparam logic [CW-1:0]         CNT_ONE = CW'(1);
   localparam logic [ADDR_LINES-1:0] PTR_ONE = ADDR_LINES'(1);

   // Storage: no reset, contents survive rstn_i but become unreachable
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [ADDR_LINES-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_LINES-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q,  count_d;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  valid_q,  valid_d;
   logic                  ovf_q,    ovf_d;
   logic                  unf_q,    unf_d;

   logic is_marker;
   logic full;
   logic empty;
   logic wr_acc;
   logic rd_acc;

   // Status flags come straight from the registered count (no look-ahead)
   assign full  = (count_q == DEPTH_C);
   assign empty = (count_q == '0);

`ifdef FIFO_MARKER_FILTER_EN
   logic start_q, start_d;

   assign is_marker = (data_i == MARKER);

   // A marker presented with wr_en yields a one-cycle start pulse
   always_comb begin
      start_d = wr_en & is_marker;
   end

   // Start pulse register
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         start_q <= 1'b0;
      end else begin
         start_q <= start_d;
      end
   end

   assign start_o = start_q;
`else
   // Filter not built: MARKER is intentionally unused
   logic unused_marker_bits;
   assign unused_marker_bits = ^MARKER;
   assign is_marker          = 1'b0;
   assign start_o            = 1'b0;
`endif

   // Acceptance: when full a concurrent read wins, when empty a concurrent
   // write wins; there is no write-to-read bypass
   assign wr_acc = wr_en & ~full & ~is_marker;
   assign rd_acc = rd_en & ~empty;

   // Next-state for pointers, occupancy, valid strobe and sticky error flags
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      valid_d  = rd_acc;
      ovf_d    = ovf_q | (wr_en & full & ~is_marker);
      unf_d    = unf_q | (rd_en & empty);

      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (rd_acc) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end

      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Control state registers with synchronous active-low reset
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   // RAM write port
   always_ff @(posedge clk_i) begin
      if (wr_acc) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   // RAM read port with registered output; holds its value between reads
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         data_q <= '0;
      end else if (rd_acc) begin
         data_q <= mem_q[rd_ptr_q];
      end
   end

   assign data_o         = data_q;
   assign valid_o        = valid_q;
   assign full_o         = full;
   assign empty_o        = empty;
   assign almost_full_o  = (count_q >= AF_C);
   assign almost_empty_o = (count_q <= AE_C);
   assign count_o        = count_q;
   assign overflow_o     = ovf_q;
   assign underflow_o    = unf_q;

endmodule

// File: tb/tb_sync_fifo_stream.sv
// tb_sync_fifo_stream
// Directed bench for sync_fifo_stream with ADDR_LINES=3 (DEPTH=8),
// AF_THRESH=4, AE_THRESH=2. Inputs change 1 time unit after a rising edge
// and outputs are checked at that same point, so each check sees the state
// left by the edge just taken. Marker expectations follow
// FIFO_MARKER_FILTER_EN.

module tb_sync_fifo_stream;

   localparam int DW = 32;
   localparam int AL = 3;

   logic          clk_i;
   logic          rstn_i;
   logic          wr_en;
   logic [DW-1:0] data_i;
   logic          rd_en;
   logic [DW-1:0] data_o;
   logic          valid_o;
   logic          full_o;
   logic          empty_o;
   logic          almost_full_o;
   logic          almost_empty_o;
   logic [AL:0]   count_o;
   logic          overflow_o;
   logic          underflow_o;
   logic          start_o;

   int n_checks = 0;
   int n_fail   = 0;

   sync_fifo_stream #(
      .DATA_WIDTH (DW),
      .ADDR_LINES (AL),
      .AF_THRESH  (4),
      .AE_THRESH  (2),
      .MARKER     (32'h7F90_0000)
   ) dut (
      .clk_i          (clk_i),
      .rstn_i         (rstn_i),
      .wr_en          (wr_en),
      .data_i         (data_i),
      .rd_en          (rd_en),
      .data_o         (data_o),
      .valid_o        (valid_o),
      .full_o         (full_o),
      .empty_o        (empty_o),
      .almost_full_o  (almost_full_o),
      .almost_empty_o (almost_empty_o),
      .count_o        (count_o),
      .overflow_o     (overflow_o),
      .underflow_o    (underflow_o),
      .start_o        (start_o)
   );

   // Clock
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Advance one rising edge and settle
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic w, input logic [DW-1:0] d, input logic r);
      wr_en  = w;
      data_i = d;
      rd_en  = r;
   endtask

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_count"}, DW'(count_o), 32'd0);
      check({tag, "_empty"}, DW'(empty_o), 32'd1);
      check({tag, "_ae"},    DW'(almost_empty_o), 32'd1);
      check({tag, "_full"},  DW'(full_o), 32'd0);
      check({tag, "_af"},    DW'(almost_full_o), 32'd0);
      check({tag, "_valid"}, DW'(valid_o), 32'd0);
      check({tag, "_data"},  data_o, 32'd0);
      check({tag, "_ovf"},   DW'(overflow_o), 32'd0);
      check({tag, "_unf"},   DW'(underflow_o), 32'd0);
      check({tag, "_start"}, DW'(start_o), 32'd0);
   endtask

   initial begin
      rstn_i = 1'b0;
      drive(1'b0, '0, 1'b0);

      // ---- Reset state
      tick();
      tick();
      check_reset_state("rst");
      rstn_i = 1'b1;

      // ---- Fill 0..7, watching threshold boundaries
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, DW'(i), 1'b0);
         tick();
         check("fill_count", DW'(count_o), DW'(i + 1));
         check("fill_ae",    DW'(almost_empty_o), DW'((i + 1) <= 2));
         check("fill_af",    DW'(almost_full_o), DW'((i + 1) >= 4));
         check("fill_full",  DW'(full_o), DW'((i + 1) == 8));
      end
      drive(1'b0, '0, 1'b0);
      check("fill_empty", DW'(empty_o), 32'd0);

      // ---- Drain 8, data one edge after rd_en
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, '0, 1'b1);
         tick();
         check("drain_data",  data_o, DW'(i));
         check("drain_valid", DW'(valid_o), 32'd1);
         check("drain_count", DW'(count_o), DW'(7 - i));
      end
      drive(1'b0, '0, 1'b0);
      tick();
      check("drain_valid_off", DW'(valid_o), 32'd0);
      check("drain_hold",      data_o, 32'd7);
      check("drain_empty",     DW'(empty_o), 32'd1);
      check("drain_ovf",       DW'(overflow_o), 32'd0);
      check("drain_unf",       DW'(underflow_o), 32'd0);

      // ---- Wrap-around: move pointers to 5, then fill 8 across the wrap
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 32'h100 + DW'(i), 1'b0);
         tick();
      end
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, '0, 1'b1);
         tick();
         check("wrap_pre_data", data_o, 32'h100 + DW'(i));
      end
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 32'h200 + DW'(i), 1'b0);
         tick();
      end
      drive(1'b0, '0, 1'b0);
      check("wrap_count", DW'(count_o), 32'd8);
      check("wrap_full",  DW'(full_o), 32'd1);
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, '0, 1'b1);
         tick();
         check("wrap_data", data_o, 32'h200 + DW'(i));
      end
      drive(1'b0, '0, 1'b0);
      tick();
      check("wrap_empty", DW'(empty_o), 32'd1);

      // ---- Simultaneous read/write at count 3
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h300 + DW'(i), 1'b0);
         tick();
      end
      check("rw3_start_count", DW'(count_o), 32'd3);
      for (int k = 0; k < 10; k++) begin
         drive(1'b1, 32'h303 + DW'(k), 1'b1);
         tick();
         check("rw3_count", DW'(count_o), 32'd3);
         check("rw3_data",  data_o, 32'h300 + DW'(k));
         check("rw3_valid", DW'(valid_o), 32'd1);
      end
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, '0, 1'b1);
         tick();
         check("rw3_tail", data_o, 32'h30A + DW'(k));
      end
      drive(1'b0, '0, 1'b0);
      tick();
      check("rw3_empty", DW'(empty_o), 32'd1);

      // ---- Simultaneous read/write at full: read wins, overflow sets
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 32'h400 + DW'(i), 1'b0);
         tick();
      end
      check("rwf_ovf_before", DW'(overflow_o), 32'd0);
      drive(1'b1, 32'h4FF, 1'b1);
      tick();
      drive(1'b0, '0, 1'b0);
      check("rwf_count", DW'(count_o), 32'd7);
      check("rwf_ovf",   DW'(overflow_o), 32'd1);
      check("rwf_data",  data_o, 32'h400);
      for (int i = 1; i < 8; i++) begin
         drive(1'b0, '0, 1'b1);
         tick();
         check("rwf_drain", data_o, 32'h400 + DW'(i));
      end
      drive(1'b0, '0, 1'b0);
      tick();
      check("rwf_empty", DW'(empty_o), 32'd1);

      // ---- Simultaneous read/write at empty: write wins, underflow sets
      check("rwe_unf_before", DW'(underflow_o), 32'd0);
      drive(1'b1, 32'h500, 1'b1);
      tick();
      drive(1'b0, '0, 1'b0);
      check("rwe_count", DW'(count_o), 32'd1);
      check("rwe_unf",   DW'(underflow_o), 32'd1);
      check("rwe_valid", DW'(valid_o), 32'd0);
      check("rwe_ovf",   DW'(overflow_o), 32'd1);
      drive(1'b0, '0, 1'b1);
      tick();
      drive(1'b0, '0, 1'b0);
      check("rwe_data", data_o, 32'h500);

      // ---- Marker word in the stream
      drive(1'b1, 32'h0000_AAAA, 1'b0);
      tick();
      check("mk_start_a", DW'(start_o), 32'd0);
      drive(1'b1, 32'h7F90_0000, 1'b0);
      tick();
`ifdef FIFO_MARKER_FILTER_EN
      check("mk_start_pulse", DW'(start_o), 32'd1);
`else
      check("mk_start_pulse", DW'(start_o), 32'd0);
`endif
      drive(1'b1, 32'h0000_BBBB, 1'b0);
      tick();
      drive(1'b0, '0, 1'b0);
      check("mk_start_end", DW'(start_o), 32'd0);
`ifdef FIFO_MARKER_FILTER_EN
      check("mk_count", DW'(count_o), 32'd2);
`else
      check("mk_count", DW'(count_o), 32'd3);
`endif
      drive(1'b0, '0, 1'b1);
      tick();
      check("mk_rd_a", data_o, 32'h0000_AAAA);
`ifndef FIFO_MARKER_FILTER_EN
      tick();
      check("mk_rd_marker", data_o, 32'h7F90_0000);
`endif
      tick();
      drive(1'b0, '0, 1'b0);
      check("mk_rd_b", data_o, 32'h0000_BBBB);
      tick();
      check("mk_empty", DW'(empty_o), 32'd1);

      // ---- Synchronous reset mid-stream
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 32'h600 + DW'(i), 1'b0);
         tick();
      end
      drive(1'b0, '0, 1'b0);
      check("mid_count", DW'(count_o), 32'd5);
      rstn_i = 1'b0;
      tick();
      check_reset_state("mid_rst");
      rstn_i = 1'b1;
      drive(1'b1, 32'h777, 1'b0);
      tick();
      check("post_count", DW'(count_o), 32'd1);
      drive(1'b0, '0, 1'b1);
      tick();
      drive(1'b0, '0, 1'b0);
      check("post_data",  data_o, 32'h777);
      check("post_valid", DW'(valid_o), 32'd1);
      check("post_empty", DW'(empty_o), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
